// File: rtl/ahbl_ram_ws.sv
// ahbl_ram_ws : AHB-Lite single-port RAM slave with configurable wait states
//
// Purpose
//   Byte-addressable RAM of 2**ADDR_WIDTH bytes, organised as 32-bit words,
//   reached through an AHB-Lite slave port. Legal transfers get an OKAY
//   response after WAIT_STATES extra cycles. Illegal transfers get a
//   two-cycle ERROR response when ERR_EN is set; otherwise they are served
//   with the address wrapped into the array.
//
// Ports
//   HCLK       in   1   clock, every register updates on the rising edge
//   HRESET     in   1   synchronous active-high reset
//   HSEL       in   1   slave select
//   HADDR      in  32   byte address (address phase)
//   HTRANS     in   2   transfer type, bit 1 marks NONSEQ/SEQ
//   HSIZE      in   3   0 byte, 1 halfword, 2 word
//   HWRITE     in   1   1 = write
//   HREADY     in   1   bus-level ready
//   HWDATA     in  32   write data (data phase)
//   HRDATA     out 32   read data, zero outside a read's final data cycle
//   HREADYOUT  out  1   slave ready
//   HRESP      out  1   0 OKAY, 1 ERROR

module ahbl_ram_ws #(
   parameter int ADDR_WIDTH  = 13,
   parameter int WAIT_STATES = 0,
   parameter bit ERR_EN      = 1'b1
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   output logic [31:0] HRDATA,
   output logic        HREADYOUT,
   output logic        HRESP
);

   localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
   // WAIT counts down to zero, so it is loaded with one less than the wait count
   localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ERR1,
      ERR2
   } state_t;

   state_t                state;
   state_t                state_next;
   logic [2:0]            wait_cnt;
   logic [2:0]            wait_cnt_next;

   logic                  req_valid;
   logic                  req_illegal;

   logic                  addr_valid;
   logic                  addr_write;
   logic                  addr_err;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [2:0]            size_q;

   logic [ADDR_WIDTH-3:0] word_idx;
   logic [3:0]            lane_en;
   logic                  data_final;
   logic                  do_write;

   logic [31:0]           mem [WORDS];

   // Decode of the address phase currently on the bus. Anything outside the
   // array, oversized or misaligned counts as illegal.
   assign req_valid   = HSEL & HTRANS[1];
   assign req_illegal = (HSIZE > 3'd2)
                      | ((HSIZE == 3'd1) & HADDR[0])
                      | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00))
                      | ((HADDR >> ADDR_WIDTH) != 32'd0);

   // Address-phase capture. The bus only advances when HREADY is high, so the
   // captured transfer is held for the whole of a stretched data phase. Only
   // the valid flag needs a reset; the rest is qualified by it.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         addr_valid <= 1'b0;
      end else if (HREADY) begin
         addr_valid <= req_valid;
         addr_write <= HWRITE;
         addr_err   <= req_illegal & ERR_EN;
         addr_q     <= HADDR[ADDR_WIDTH-1:0];
         size_q     <= HSIZE;
      end
   end

   // State and wait-counter registers.
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state    <= IDLE;
         wait_cnt <= 3'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Next-state logic. IDLE and ERR2 are both the last cycle of a data phase,
   // so both accept a new address phase and pick its path straight away:
   // errors go to ERR1 and skip wait states, legal transfers go to WAIT only
   // when wait states are configured.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      case (state)
         IDLE, ERR2: begin
            state_next = IDLE;
            if (HREADY && req_valid) begin
               if (req_illegal && ERR_EN) begin
                  state_next = ERR1;
               end else if (WAIT_STATES > 0) begin
                  state_next    = WAIT;
                  wait_cnt_next = WAIT_LOAD;
               end
            end
         end
         WAIT: begin
            if (wait_cnt == 3'd0) begin
               state_next = IDLE;
            end else begin
               wait_cnt_next = wait_cnt - 3'd1;
            end
         end
         ERR1: begin
            state_next = ERR2;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // A legal captured transfer reaches its final data cycle once the FSM is
   // back in IDLE; this is the only cycle that reads or writes the array.
   assign data_final = (state == IDLE) & addr_valid & ~addr_err;
   assign do_write   = data_final & addr_write & HREADY & ~HRESET;
   assign word_idx   = addr_q[ADDR_WIDTH-1:2];

   // Bus outputs. Read data is the whole addressed word, lanes left in place,
   // and is forced to zero in every other cycle.
   always_comb begin
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      HRDATA    = 32'd0;
      if ((state == WAIT) || (state == ERR1)) begin
         HREADYOUT = 1'b0;
      end
      if ((state == ERR1) || (state == ERR2)) begin
         HRESP = 1'b1;
      end
      if (data_final && !addr_write) begin
         HRDATA = mem[word_idx];
      end
   end

   // Little-endian byte-lane enables. Misaligned halfwords keep the lane pair
   // chosen by address bit 1; oversize transfers (only reachable with errors
   // disabled) write the whole word.
   always_comb begin
      lane_en = 4'b0000;
      case (size_q)
         3'd0:    lane_en[addr_q[1:0]] = 1'b1;
         3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
         default: lane_en = 4'b1111;
      endcase
   end

   // Array write port. The array has no reset so contents survive HRESET.
   always_ff @(posedge HCLK) begin
      if (do_write) begin
         for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
               mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
         end
      end
   end

endmodule
